id_pipe_stage: RTL and testbench
================================

// Module: id_pipe_stage
// PURPOSE
//  Registered RV integer decode stage, XLEN-parametrised. Sits between IF and EX.
//  Decodes OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE and SYSTEM
//  (ECALL/EBREAK), drives regfile read ports and builds operands.
//  Adds over the combinational decoder: valid/ready handshake, output pipeline
//  register, load-use stall with bubble insertion, flush and illegal-instruction flag.
// PARAMETERS
//  XLEN      64  datapath width (32 or 64); immediates sign-extended to XLEN
//  LU_STALL  1   1 = enable load-use interlock; 0 = ready ignores hazards
// PORTS
//  clk              in   1     clock
//  rst              in   1     synchronous reset, active-high
//  in_valid         in   1     IF presents in_inst/in_pc
//  in_ready         out  1     stage accepts in_inst this cycle
//  in_inst          in   32    instruction word
//  in_pc            in   XLEN  instruction PC
//  flush            in   1     kill held and incoming instruction (branch redirect)
//  rs1_r_ena/addr   out  1/5   regfile read port 1 (combinational from in_inst)
//  rs2_r_ena/addr   out  1/5   regfile read port 2 (combinational from in_inst)
//  rs1_data/rs2_data in  XLEN  regfile read data, same cycle
//  out_valid        out  1     output register holds a decoded instruction
//  out_ready        in   1     EX accepts output this cycle
//  out_pc           out  XLEN  registered PC
//  out_inst_type    out  5     one-hot: [4]arith [3]logic [2]ld/st [1]jump [0]sys
//  out_inst_opcode  out  8     operation code, table below
//  out_op1/out_op2  out  XLEN  ALU operands
//  out_imm          out  XLEN  sign-extended B/J/S/I immediate (offset or ld/st addr)
//  out_rs2_data     out  XLEN  store data / branch compare operand
//  out_rd_w_ena/addr out 1/5   writeback enable/address (ena=0 when rd==0)
//  out_illegal      out  1     undecodable opcode/func3/func7; type and ena all 0
// BEHAVIOUR
//  Reset: all out_* 0, in_ready 0 during reset cycle, shadow load tracker cleared.
//  Load: register loads when in_valid & in_ready; latency 1 cycle in->out.
//  in_ready = (~out_valid | out_ready) & ~hazard & ~flush.
//  out_valid: set on load; cleared when out_ready & no new load; held when ~out_ready.
//  Output held stable while out_valid & ~out_ready (no bubble overwrite).
//  Opcodes: ADD/ADDI 11 SUB 12 SLT(I) 13 SLTU(I) 14 LUI 15 AUIPC 16;
//   AND(I) 21 OR(I) 22 XOR(I) 23 SLL(I) 24 SRL(I) 25 SRA(I) 26;
//   LOAD 40|func3, STORE 48|func3; JAL 81 JALR 82; BRANCH 90|func3;
//   ECALL 01 EBREAK 02 (all hex). SRAI/SRA select via inst[30]; shamt inst[25:20]
//   for XLEN=64, inst[24:20] for XLEN=32 (inst[25]=1 illegal when XLEN=32).
//  Operands: R: rs1,rs2. I-arith/load/JALR: rs1, sext(imm[31:20]) (JALR op2=4 link,
//   imm=target offset). LUI: 0, sext({inst[31:12],12'b0}). AUIPC: pc, U-imm.
//   JAL: pc, 4, imm=J-imm. BRANCH: rs1, rs2, imm=B-imm. STORE: rs1, S-imm,
//   out_rs2_data=rs2. SYSTEM: 0,0. Unused read ports: ena 0, addr 0.
//  Hazard (LU_STALL=1): hazard when incoming uses rs1/rs2 (nonzero) equal to rd of
//   (a) load held in output register, or (b) shadow: load handed to EX last cycle.
//   Shadow set on out_valid&out_ready&load, cleared next cycle unconditionally.
//   Effect: dependent instruction waits; one bubble (out_valid 0) precedes it.
//  Flush: out_valid<=0, shadow cleared, in_inst that cycle dropped; flush beats
//   simultaneous in_valid and out_ready; flush during rst has no extra effect.
//  Reset mid-stall: all state cleared, stalled instruction must be re-presented.
//  Illegal: out_valid 1, out_illegal 1, rd_w_ena 0, type/opcode 0.
// TESTING
//  ADDI x1,x2,-5, rs1_data=10 -> next cycle out_valid, opcode 11, op1 10,
//   op2 FFFF..FFFB, rd 1.
//  LD x5,0(x1) then ADD x6,x5,x3 back-to-back, out_ready=1 -> ADD in_ready low
//   2 cycles, one bubble, ADD appears 3 cycles after LD.
//  out_ready=0 for 4 cycles with SUB held -> outputs stable, in_ready 0; release ->
//   next instruction loads same cycle.
//  flush with in_valid=1 and valid output -> out_valid 0 next cycle, instruction lost.
//  LUI x7,0x80000 (XLEN=64) -> op2 FFFFFFFF80000000; ADDI x0,... -> rd_w_ena 0.
//  inst 0xFFFFFFFF -> out_illegal 1, rd_w_ena 0; rst mid-stall -> all outputs 0.

Source files
------------

// File: rtl/id_pipe_stage.sv
// Registered RV integer decode stage between IF and EX.
// Decodes the incoming instruction combinationally. It drives the regfile read
// ports in the same cycle and captures the decoded operands in an output
// register that uses a valid/ready handshake. A load-use interlock holds back
// any instruction that needs the result of a load that is still in flight.
module id_pipe_stage #(
    parameter int XLEN     = 64,
    parameter bit LU_STALL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            rs1_r_ena,
    output logic [4:0]      rs1_r_addr,
    output logic            rs2_r_ena,
    output logic [4:0]      rs2_r_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_inst_type,
    output logic [7:0]      out_inst_opcode,
    output logic [XLEN-1:0] out_op1,
    output logic [XLEN-1:0] out_op2,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_rs2_data,
    output logic            out_rd_w_ena,
    output logic [4:0]      out_rd_w_addr,
    output logic            out_illegal
);

    typedef enum logic [6:0] {
        MAJ_OP     = 7'b0110011,
        MAJ_OPIMM  = 7'b0010011,
        MAJ_LUI    = 7'b0110111,
        MAJ_AUIPC  = 7'b0010111,
        MAJ_JAL    = 7'b1101111,
        MAJ_JALR   = 7'b1100111,
        MAJ_BRANCH = 7'b1100011,
        MAJ_LOAD   = 7'b0000011,
        MAJ_STORE  = 7'b0100011,
        MAJ_SYSTEM = 7'b1110011
    } major_e;

    localparam logic [7:0] OP_ADD  = 8'h11, OP_SUB  = 8'h12, OP_SLT = 8'h13, OP_SLTU = 8'h14;
    localparam logic [7:0] OP_LUI  = 8'h15, OP_AUIPC = 8'h16;
    localparam logic [7:0] OP_AND  = 8'h21, OP_OR   = 8'h22, OP_XOR = 8'h23;
    localparam logic [7:0] OP_SLL  = 8'h24, OP_SRL  = 8'h25, OP_SRA = 8'h26;
    localparam logic [7:0] OP_JAL  = 8'h81, OP_JALR = 8'h82;
    localparam logic [7:0] OP_ECALL = 8'h01, OP_EBREAK = 8'h02;

    // Shared func3 -> operation map for the register and immediate ALU forms.
    function automatic logic [7:0] alu_code(input logic [2:0] f3);
        case (f3)
            3'd0:    alu_code = OP_ADD;
            3'd1:    alu_code = OP_SLL;
            3'd2:    alu_code = OP_SLT;
            3'd3:    alu_code = OP_SLTU;
            3'd4:    alu_code = OP_XOR;
            3'd5:    alu_code = OP_SRL;
            3'd6:    alu_code = OP_OR;
            default: alu_code = OP_AND;
        endcase
    endfunction

    major_e          major;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    logic [5:0]      shamt;
    logic            sh_ok;

    assign major = major_e'(in_inst[6:0]);
    assign rd    = in_inst[11:7];
    assign f3    = in_inst[14:12];
    assign rs1   = in_inst[19:15];
    assign rs2   = in_inst[24:20];
    assign f7    = in_inst[31:25];
    assign imm_i = XLEN'($signed(in_inst[31:20]));
    assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
    assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
    assign imm_u = XLEN'($signed({in_inst[31:12], 12'h000}));
    // An RV32 shift amount is five bits, so inst[25] must be clear there.
    assign shamt = (XLEN == 64) ? in_inst[25:20] : {1'b0, in_inst[24:20]};
    assign sh_ok = (XLEN == 64) || !in_inst[25];

    logic            d_bad, d_use1, d_use2, d_writes;
    logic [4:0]      d_type;
    logic [7:0]      d_opc;
    logic [XLEN-1:0] d_op1, d_op2, d_imm;

    // Decode the incoming word into operation code, operands and register usage.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        d_bad    = 1'b0;
        d_use1   = 1'b0;
        d_use2   = 1'b0;
        d_writes = 1'b0;
        d_type   = '0;
        d_opc    = '0;
        d_op1    = '0;
        d_op2    = '0;
        d_imm    = '0;
        case (major)
            MAJ_OP: begin
                {d_use1, d_use2, d_writes} = 3'b111;
                d_op1 = rs1_data;
                d_op2 = rs2_data;
                if (f7 == 7'b0000000)                     d_opc = alu_code(f3);
                else if (f7 == 7'b0100000 && f3 == 3'd0)  d_opc = OP_SUB;
                else if (f7 == 7'b0100000 && f3 == 3'd5)  d_opc = OP_SRA;
                else                                      d_bad = 1'b1;
            end
            MAJ_OPIMM: begin
                {d_use1, d_writes} = 2'b11;
                d_op1 = rs1_data;
                d_op2 = imm_i;
                d_imm = imm_i;
                d_opc = alu_code(f3);
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    d_op2 = XLEN'(shamt);
                    if (!sh_ok)                                      d_bad = 1'b1;
                    else if (in_inst[31:26] == 6'b010000 && f3 == 3'd5) d_opc = OP_SRA;
                    else if (in_inst[31:26] != 6'b000000)            d_bad = 1'b1;
                end
            end
            MAJ_LUI: begin
                d_writes = 1'b1;
                d_op2    = imm_u;
                d_opc    = OP_LUI;
            end
            MAJ_AUIPC: begin
                d_writes = 1'b1;
                d_op1    = in_pc;
                d_op2    = imm_u;
                d_opc    = OP_AUIPC;
            end
            MAJ_JAL: begin
                d_writes = 1'b1;
                d_op1    = in_pc;
                d_op2    = XLEN'(3'd4);
                d_imm    = imm_j;
                d_opc    = OP_JAL;
            end
            MAJ_JALR: begin
                {d_use1, d_writes} = 2'b11;
                d_op1 = rs1_data;
                d_op2 = XLEN'(3'd4);
                d_imm = imm_i;
                d_opc = OP_JALR;
                d_bad = (f3 != 3'd0);
            end
            MAJ_BRANCH: begin
                {d_use1, d_use2} = 2'b11;
                d_op1 = rs1_data;
                d_op2 = rs2_data;
                d_imm = imm_b;
                d_opc = {5'b10010, f3};
                d_bad = (f3 == 3'd2 || f3 == 3'd3);
            end
            MAJ_LOAD: begin
                {d_use1, d_writes} = 2'b11;
                d_op1 = rs1_data;
                d_op2 = imm_i;
                d_imm = imm_i;
                d_opc = {5'b01000, f3};
                d_bad = (f3 == 3'd7) || (XLEN == 32 && (f3 == 3'd3 || f3 == 3'd6));
            end
            MAJ_STORE: begin
                {d_use1, d_use2} = 2'b11;
                d_op1 = rs1_data;
                d_op2 = imm_s;
                d_imm = imm_s;
                d_opc = {5'b01001, f3};
                d_bad = f3[2] || (XLEN == 32 && f3 == 3'd3);
            end
            MAJ_SYSTEM: begin
                if (in_inst == 32'h0000_0073)      d_opc = OP_ECALL;
                else if (in_inst == 32'h0010_0073) d_opc = OP_EBREAK;
                else                               d_bad = 1'b1;
            end
            default: d_bad = 1'b1;
        endcase
        case (d_opc[7:4])
            4'h1:       d_type = 5'b10000;
            4'h2:       d_type = 5'b01000;
            4'h4:       d_type = 5'b00100;
            4'h8, 4'h9: d_type = 5'b00010;
            default:    d_type = 5'b00001;
        endcase
        if (d_bad) begin
            {d_use1, d_use2, d_writes} = 3'b000;
            d_type = '0;
            d_opc  = '0;
            d_op1  = '0;
            d_op2  = '0;
            d_imm  = '0;
        end
    end

    assign rs1_r_ena  = d_use1;
    assign rs1_r_addr = d_use1 ? rs1 : 5'd0;
    assign rs2_r_ena  = d_use2;
    assign rs2_r_addr = d_use2 ? rs2 : 5'd0;

    logic       shadow_vld;
    logic [4:0] shadow_rd;
    logic       out_is_load, hit1, hit2, hazard, load;

    // A source matches a load that is held here or was handed to EX last cycle.
    always_comb begin
        out_is_load = out_valid && (out_inst_opcode[7:3] == 5'b01000);
        hit1 = d_use1 && (rs1 != 5'd0) &&
               ((out_is_load && rs1 == out_rd_w_addr) || (shadow_vld && rs1 == shadow_rd));
        hit2 = d_use2 && (rs2 != 5'd0) &&
               ((out_is_load && rs2 == out_rd_w_addr) || (shadow_vld && rs2 == shadow_rd));
        hazard   = LU_STALL && (hit1 || hit2);
        in_ready = !rst && (!out_valid || out_ready) && !hazard && !flush;
        load     = in_valid && in_ready;
    end

    // Output register, handshake state and the one-cycle shadow of a retired load.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the datapath fields are reset as well, so every output reads 0 after reset.
            out_valid       <= 1'b0;
            out_pc          <= '0;
            out_inst_type   <= '0;
            out_inst_opcode <= '0;
            out_op1         <= '0;
            out_op2         <= '0;
            out_imm         <= '0;
            out_rs2_data    <= '0;
            out_rd_w_ena    <= 1'b0;
            out_rd_w_addr   <= '0;
            out_illegal     <= 1'b0;
            shadow_vld      <= 1'b0;
            shadow_rd       <= '0;
        end else begin
            // NOTE: non-blocking assignments make all state change together at the edge.
            shadow_vld <= !flush && out_ready && out_is_load;
            shadow_rd  <= out_rd_w_addr;
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid       <= 1'b1;
                out_pc          <= in_pc;
                out_inst_type   <= d_type;
                out_inst_opcode <= d_opc;
                out_op1         <= d_op1;
                out_op2         <= d_op2;
                out_imm         <= d_imm;
                out_rs2_data    <= d_use2 ? rs2_data : '0;
                out_rd_w_ena    <= d_writes && (rd != 5'd0);
                out_rd_w_addr   <= d_writes ? rd : 5'd0;
                out_illegal     <= d_bad;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Bench for id_pipe_stage. Directed scenarios are followed by randomized
// traffic. Every cycle is compared against a reference model. The model
// decodes instructions with plain integer arithmetic and follows the
// handshake, flush and load-use rules one cycle at a time.
module tb_id_pipe_stage;

    localparam int XLEN = 64;

    logic            clk;
    logic            rst;
    logic            in_valid, in_ready, flush;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            rs1_r_ena, rs2_r_ena;
    logic [4:0]      rs1_r_addr, rs2_r_addr;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_pc, out_op1, out_op2, out_imm, out_rs2_data;
    logic [4:0]      out_inst_type, out_rd_w_addr;
    logic [7:0]      out_inst_opcode;
    logic            out_rd_w_ena, out_illegal;

    logic [63:0] regs [32];
    assign rs1_data = regs[rs1_r_addr];
    assign rs2_data = regs[rs2_r_addr];

    id_pipe_stage #(.XLEN(XLEN), .LU_STALL(1'b1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .flush(flush),
        .rs1_r_ena(rs1_r_ena), .rs1_r_addr(rs1_r_addr),
        .rs2_r_ena(rs2_r_ena), .rs2_r_addr(rs2_r_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst_type(out_inst_type), .out_inst_opcode(out_inst_opcode),
        .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
        .out_rs2_data(out_rs2_data),
        .out_rd_w_ena(out_rd_w_ena), .out_rd_w_addr(out_rd_w_addr),
        .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ill;
        logic [4:0]  typ;
        logic [7:0]  opc;
        logic [63:0] pc, op1, op2, imm, rs2d;
        logic        wen;
        logic [4:0]  wad;
        logic        r1e;
        logic [4:0]  r1a;
        logic        r2e;
        logic [4:0]  r2a;
        logic        ld;
    } exp_t;

    localparam logic [7:0] ALU_OF_F3 [8] = '{8'h11, 8'h24, 8'h13, 8'h14, 8'h23, 8'h25, 8'h22, 8'h21};

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t m_out;
    logic m_valid, m_sh, last_ready;
    logic [4:0] m_sh_rd;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Reference decode from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [63:0] pc);
        exp_t   e  = '0;
        longint s  = longint'($signed(w));
        longint ii = s >>> 20;
        longint si = ((s >>> 25) <<< 5) | longint'(w[11:7]);
        longint bi = ((s >>> 31) <<< 12) | (longint'(w[7]) << 11) |
                     (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
        longint ji = ((s >>> 31) <<< 20) | (longint'(w[19:12]) << 12) |
                     (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
        longint ui = s & ~longint'(12'hFFF);
        logic [2:0] f3 = w[14:12];
        logic [4:0] rd = w[11:7];
        logic [4:0] a  = w[19:15];
        logic [4:0] b  = w[24:20];
        bit ok = 1, ua = 0, ub = 0, wr = 0;
        case (w[6:0])
            7'h33: begin
                ua = 1; ub = 1; wr = 1; e.op1 = regs[a]; e.op2 = regs[b];
                if (w[31:25] == 7'h00)                   e.opc = ALU_OF_F3[f3];
                else if (w[31:25] == 7'h20 && f3 == 0)   e.opc = 8'h12;
                else if (w[31:25] == 7'h20 && f3 == 5)   e.opc = 8'h26;
                else                                     ok = 0;
            end
            7'h13: begin
                ua = 1; wr = 1; e.op1 = regs[a]; e.op2 = ii; e.imm = ii;
                e.opc = ALU_OF_F3[f3];
                if (f3 == 1 || f3 == 5) begin
                    e.op2 = longint'(w[25:20]);
                    if (w[31:26] == 6'd16 && f3 == 5) e.opc = 8'h26;
                    else if (w[31:26] != 6'd0)        ok = 0;
                end
            end
            7'h37: begin wr = 1; e.op2 = ui; e.opc = 8'h15; end
            7'h17: begin wr = 1; e.op1 = pc; e.op2 = ui; e.opc = 8'h16; end
            7'h6F: begin wr = 1; e.op1 = pc; e.op2 = 4; e.imm = ji; e.opc = 8'h81; end
            7'h67: begin
                ua = 1; wr = 1; e.op1 = regs[a]; e.op2 = 4; e.imm = ii; e.opc = 8'h82;
                if (f3 != 0) ok = 0;
            end
            7'h63: begin
                ua = 1; ub = 1; e.op1 = regs[a]; e.op2 = regs[b]; e.imm = bi;
                e.opc = 8'h90 + 8'(f3);
                if (f3 == 2 || f3 == 3) ok = 0;
            end
            7'h03: begin
                ua = 1; wr = 1; e.op1 = regs[a]; e.op2 = ii; e.imm = ii;
                e.opc = 8'h40 + 8'(f3); e.ld = 1;
                if (f3 == 7) ok = 0;
            end
            7'h23: begin
                ua = 1; ub = 1; e.op1 = regs[a]; e.op2 = si; e.imm = si;
                e.opc = 8'h48 + 8'(f3);
                if (f3 > 3) ok = 0;
            end
            7'h73: begin
                if (w == 32'h0000_0073)      e.opc = 8'h01;
                else if (w == 32'h0010_0073) e.opc = 8'h02;
                else                         ok = 0;
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            e = '0;
            e.ill = 1;
        end else begin
            if (e.opc inside {[8'h11:8'h16]})                    e.typ = 5'b10000;
            else if (e.opc inside {[8'h21:8'h26]})               e.typ = 5'b01000;
            else if (e.opc inside {[8'h40:8'h4F]})               e.typ = 5'b00100;
            else if (e.opc inside {8'h81, 8'h82, [8'h90:8'h97]}) e.typ = 5'b00010;
            else                                                 e.typ = 5'b00001;
            e.r1e  = ua;
            e.r1a  = ua ? a : 5'd0;
            e.r2e  = ub;
            e.r2a  = ub ? b : 5'd0;
            e.rs2d = ub ? regs[b] : 64'd0;
            e.wen  = wr && rd != 0;
            e.wad  = wr ? rd : 5'd0;
        end
        e.pc = pc;
        return e;
    endfunction

    function automatic logic src_hit(input logic en, input logic [4:0] a);
        return en && a != 0 &&
               ((m_valid && m_out.ld && m_out.wad == a) || (m_sh && m_sh_rd == a));
    endfunction

    // One clock: drive at negedge, check combinational outputs, advance model, check registers.
    task automatic step(input logic v, input logic [31:0] w, input logic [63:0] pc,
                        input logic fl, input logic ordy);
        exp_t d;
        logic ready, sh_next;
        @(negedge clk);
        in_valid = v; in_inst = w; in_pc = pc; flush = fl; out_ready = ordy;
        #1;
        d = ref_decode(w, pc);
        ready = !rst && (!m_valid || ordy) && !fl && !src_hit(d.r1e, d.r1a) && !src_hit(d.r2e, d.r2a);
        check("in_ready", in_ready, ready);
        check("rs1_ena", rs1_r_ena, d.r1e);
        check("rs1_addr", rs1_r_addr, d.r1a);
        check("rs2_ena", rs2_r_ena, d.r2e);
        check("rs2_addr", rs2_r_addr, d.r2a);
        last_ready = in_ready;
        if (rst) begin
            m_valid = 0; m_out = '0; m_sh = 0; m_sh_rd = 0;
        end else begin
            sh_next = !fl && m_valid && ordy && m_out.ld;
            m_sh_rd = m_out.wad;
            if (fl)               m_valid = 0;
            else if (v && ready)  begin m_valid = 1; m_out = d; end
            else if (ordy)        m_valid = 0;
            m_sh = sh_next;
        end
        @(posedge clk);
        #1;
        cyc++;
        check("out_valid", out_valid, m_valid);
        check("out_pc", out_pc, m_out.pc);
        check("out_type", out_inst_type, m_out.typ);
        check("out_opcode", out_inst_opcode, m_out.opc);
        check("out_op1", out_op1, m_out.op1);
        check("out_op2", out_op2, m_out.op2);
        check("out_imm", out_imm, m_out.imm);
        check("out_rs2_data", out_rs2_data, m_out.rs2d);
        check("out_rd_ena", out_rd_w_ena, m_out.wen);
        check("out_rd_addr", out_rd_w_addr, m_out.wad);
        check("out_illegal", out_illegal, m_out.ill);
    endtask

    function automatic logic [31:0] gen_inst();
        logic [31:0] r  = $urandom();
        logic [4:0]  rd = 5'($urandom_range(0, 7));
        logic [4:0]  a  = 5'($urandom_range(0, 7));
        logic [4:0]  b  = 5'($urandom_range(0, 7));
        logic [2:0]  f3 = 3'($urandom_range(0, 7));
        logic [5:0]  hi;
        case ($urandom_range(0, 11))
            0: return {($urandom_range(0, 7) == 0) ? r[31:25] : (r[0] ? 7'h20 : 7'h00),
                       b, a, f3, rd, 7'h33};
            1: begin
                hi = (r[1:0] == 0) ? r[31:26] : (r[2] ? 6'd16 : 6'd0);
                return {hi, r[25:20], a, f3, rd, 7'h13};
            end
            2: return {r[31:12], rd, 7'h37};
            3: return {r[31:12], rd, 7'h17};
            4: return {r[31:12], rd, 7'h6F};
            5: return {r[31:20], a, r[3] ? f3 : 3'd0, rd, 7'h67};
            6: return {r[31:25], b, a, f3, r[11:7], 7'h63};
            7, 8: return {r[31:20], a, r[4] ? f3 : 3'd3, rd, 7'h03};
            9: return {r[31:25], b, a, f3, r[11:7], 7'h23};
            10: return (r[1:0] == 0) ? 32'h0000_0073 : (r[1:0] == 1) ? 32'h0010_0073 : {r[31:7], 7'h73};
            default: return r;
        endcase
    endfunction

    localparam logic [31:0] I_ADDI = {12'hFFB, 5'd2, 3'd0, 5'd1, 7'h13};
    localparam logic [31:0] I_LD   = {12'd0, 5'd1, 3'd3, 5'd5, 7'h03};
    localparam logic [31:0] I_ADD  = {7'd0, 5'd3, 5'd5, 3'd0, 5'd6, 7'h33};
    localparam logic [31:0] I_SUB  = {7'h20, 5'd2, 5'd1, 3'd0, 5'd8, 7'h33};
    localparam logic [31:0] I_XOR  = {7'd0, 5'd2, 5'd1, 3'd4, 5'd9, 7'h33};
    localparam logic [31:0] I_LUI  = 32'h8000_03B7;
    localparam logic [31:0] I_ADX0 = {12'd1, 5'd2, 3'd0, 5'd0, 7'h13};

    initial begin
        int   low, ld_c, add_c;
        logic prev_ov;
        regs[0] = '0;
        for (int i = 1; i < 32; i++) regs[i] = {$urandom(), $urandom()};
        regs[2] = 64'd10;
        m_valid = 0; m_out = '0; m_sh = 0; m_sh_rd = 0; last_ready = 0;
        rst = 1; in_valid = 0; in_inst = '0; in_pc = '0; flush = 0; out_ready = 0;

        // Reset, with a flush and an offered instruction that must have no effect.
        step(1, I_ADDI, 64'h100, 1, 1);
        check("rst_in_ready", last_ready, 0);
        step(1, I_ADDI, 64'h100, 0, 1);
        check("rst_out_valid", out_valid, 0);
        rst = 0;

        // ADDI x1,x2,-5 with x2 = 10.
        step(1, I_ADDI, 64'h1000, 0, 1);
        check("addi_valid", out_valid, 1);
        check("addi_opcode", out_inst_opcode, 8'h11);
        check("addi_op1", out_op1, 64'd10);
        check("addi_op2", out_op2, 64'hFFFF_FFFF_FFFF_FFFB);
        check("addi_rd", out_rd_w_addr, 5'd1);

        // Back-to-back LD x5 / ADD x6,x5,x3.
        step(1, I_LD, 64'h2000, 0, 1);
        check("ld_accept", last_ready, 1);
        ld_c = cyc; add_c = -1; low = 0; prev_ov = out_valid;
        for (int k = 0; k < 8; k++) begin
            step(1, I_ADD, 64'h2004, 0, 1);
            if (last_ready) begin
                add_c = cyc;
                break;
            end
            low++;
            prev_ov = out_valid;
        end
        check("lu_stall_cycles", low, 2);
        check("lu_latency", add_c - ld_c, 3);
        check("lu_bubble", prev_ov, 0);
        check("lu_add_opcode", out_inst_opcode, 8'h11);
        check("lu_add_rd", out_rd_w_addr, 5'd6);

        // SUB held for 4 cycles while EX is not ready.
        step(0, 32'h0, 64'h0, 0, 1);
        step(1, I_SUB, 64'h3000, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(1, I_XOR, 64'h3004, 0, 0);
            check("hold_in_ready", last_ready, 0);
            check("hold_opcode", out_inst_opcode, 8'h12);
            check("hold_op1", out_op1, regs[1]);
            check("hold_op2", out_op2, regs[2]);
            check("hold_pc", out_pc, 64'h3000);
        end
        step(1, I_XOR, 64'h3004, 0, 1);
        check("release_ready", last_ready, 1);
        check("release_opcode", out_inst_opcode, 8'h23);
        check("release_pc", out_pc, 64'h3004);

        // Flush with an incoming instruction and a valid output.
        step(1, I_ADDI, 64'h4000, 1, 1);
        check("flush_ready", last_ready, 0);
        check("flush_valid", out_valid, 0);
        step(0, 32'h0, 64'h0, 0, 1);
        check("flush_lost", out_valid, 0);

        // LUI sign extension, writes to x0, illegal word.
        step(1, I_LUI, 64'h5000, 0, 1);
        check("lui_op2", out_op2, 64'hFFFF_FFFF_8000_0000);
        check("lui_op1", out_op1, 64'd0);
        check("lui_opcode", out_inst_opcode, 8'h15);
        step(1, I_ADX0, 64'h5004, 0, 1);
        check("x0_rd_ena", out_rd_w_ena, 0);
        step(1, 32'hFFFF_FFFF, 64'h5008, 0, 1);
        check("ill_valid", out_valid, 1);
        check("ill_flag", out_illegal, 1);
        check("ill_rd_ena", out_rd_w_ena, 0);
        check("ill_type", out_inst_type, 5'd0);
        check("ill_opcode", out_inst_opcode, 8'd0);

        // Reset while ADD is stalled behind a held load.
        step(1, I_LD, 64'h6000, 0, 1);
        step(1, I_ADD, 64'h6004, 0, 0);
        check("stall_ready", last_ready, 0);
        rst = 1;
        step(1, I_ADD, 64'h6004, 0, 0);
        check("rst_stall_ready", last_ready, 0);
        check("rst_stall_valid", out_valid, 0);
        check("rst_stall_pc", out_pc, 64'd0);
        check("rst_stall_op1", out_op1, 64'd0);
        check("rst_stall_opcode", out_inst_opcode, 8'd0);
        rst = 0;
        step(1, I_ADD, 64'h6004, 0, 1);
        check("represent_ready", last_ready, 1);
        check("represent_opcode", out_inst_opcode, 8'h11);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] w = gen_inst();
            logic [63:0] pc = {$urandom(), $urandom()} & ~64'h3;
            regs[$urandom_range(1, 31)] = {$urandom(), $urandom()};
            rst = ($urandom_range(0, 199) == 0);
            step($urandom_range(0, 3) != 0, w, pc, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) != 0);
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
